// File: rtl/gcm_pkg.sv
// Shared types for the GCM receive-side tag checker: GF(2^128) element type,
// reduction constant, FSM encoding and the single-step V update.
package gcm_pkg;

  typedef logic [0:127] gf128_t;

  // Index 0 is the x^0 coefficient, so R = 11100001 || 0^120 sits at the low indices.
  localparam gf128_t GCM_R = {8'he1, 120'd0};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BLK = 3'd1,
    MULT     = 3'd2,
    FINAL    = 3'd3,
    DONE     = 3'd4
  } state_t;

  // Multiply V by x: ">>" on a [0:127] vector moves bits toward higher index.
  function automatic gf128_t gf128_shift_v(input gf128_t v);
    gf128_t shifted;
    shifted = v >> 1;
    if (v[127]) begin
      shifted = shifted ^ GCM_R;
    end
    return shifted;
  endfunction

endpackage

// File: rtl/gf128_mult_serial.sv
// Iterative GF(2^128) multiplier: consumes BITS_PER_CYCLE bits of X per clock,
// pulses done_o for one cycle with the registered product on z_o.
module gf128_mult_serial
  import gcm_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [0:127] x_i,
  input  logic [0:127] h_i,
  output logic         done_o,
  output logic [0:127] z_o
);

  localparam int STEPS = 128 / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  gf128_t        z_q, z_d;
  gf128_t        v_q, v_d;
  gf128_t        y_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;
  logic          done_q;

  // Unrolled Algorithm 1 steps; y_q is pre-shifted so its next bits sit at index 0.
  always_comb begin
    z_d = z_q;
    v_d = v_q;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (y_q[k]) begin
        z_d = z_d ^ v_d;
      end
      v_d = gf128_shift_v(v_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      z_q    <= '0;
      v_q    <= '0;
      y_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        z_q   <= '0;
        v_q   <= h_i;
        y_q   <= x_i;
        cnt_q <= '0;
        run_q <= 1'b1;
      end else if (run_q) begin
        z_q   <= z_d;
        v_q   <= v_d;
        y_q   <= y_q << BITS_PER_CYCLE;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign z_o    = z_q;

endmodule

// File: rtl/gcm_tag_verify.sv
// Receive-side GCM tag checker: GHASH accumulation over AAD/ciphertext/length
// blocks, masking with E_K(J0), and a full-width compare against the received tag.
module gcm_tag_verify
  import gcm_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [0:127] i_h,
  input  logic         i_blk_valid,
  output logic         o_blk_ready,
  input  logic [0:127] i_blk_data,
  input  logic         i_blk_last,
  input  logic [0:127] i_ekj0,
  input  logic [0:127] i_tag,
  output logic         o_busy,
  output logic         o_done,
  output logic [0:127] o_tag,
  output logic         o_pass,
  output logic [2:0]   o_state
);

  // Block handshake: a block transfers on a rising edge where i_blk_valid and
  // o_blk_ready are both high; ready depends only on state, never on valid.

  state_t state_q, state_d;
  gf128_t h_q, h_d;
  gf128_t x_q, x_d;
  gf128_t ekj0_q, ekj0_d;
  gf128_t tag_q, tag_d;
  gf128_t otag_q, otag_d;
  logic   last_q, last_d;
  logic   pass_q, pass_d;

  logic   mult_start;
  logic   mult_done;
  gf128_t mult_y;
  gf128_t mult_z;
  gf128_t tag_calc;

  assign mult_y   = x_q ^ i_blk_data;
  assign tag_calc = x_q ^ ekj0_q;

  gf128_mult_serial #(
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_mult (
    .clk     (clk),
    .rst_i   (i_reset),
    .start_i (mult_start),
    .x_i     (mult_y),
    .h_i     (h_q),
    .done_o  (mult_done),
    .z_o     (mult_z)
  );

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    x_d         = x_q;
    ekj0_d      = ekj0_q;
    tag_d       = tag_q;
    otag_d      = otag_q;
    last_d      = last_q;
    pass_d      = pass_q;
    mult_start  = 1'b0;
    o_blk_ready = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          h_d     = i_h;
          x_d     = '0;
          otag_d  = '0;
          pass_d  = 1'b0;
          last_d  = 1'b0;
          state_d = WAIT_BLK;
        end
      end
      WAIT_BLK: begin
        o_blk_ready = 1'b1;
        o_busy      = 1'b1;
        if (i_blk_valid) begin
          mult_start = 1'b1;
          last_d     = i_blk_last;
          if (i_blk_last) begin
            ekj0_d = i_ekj0;
            tag_d  = i_tag;
          end
          state_d = MULT;
        end
      end
      MULT: begin
        o_busy = 1'b1;
        if (mult_done) begin
          x_d     = mult_z;
          state_d = last_q ? FINAL : WAIT_BLK;
        end
      end
      FINAL: begin
        o_busy  = 1'b1;
        o_done  = 1'b1;
        otag_d  = tag_calc;
        // Reduction over every bit of the difference: no data-dependent early exit.
        pass_d  = ~|(tag_calc ^ tag_q);
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      h_q     <= '0;
      x_q     <= '0;
      ekj0_q  <= '0;
      tag_q   <= '0;
      otag_q  <= '0;
      last_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      x_q     <= x_d;
      ekj0_q  <= ekj0_d;
      tag_q   <= tag_d;
      otag_q  <= otag_d;
      last_q  <= last_d;
      pass_q  <= pass_d;
    end
  end

  assign o_tag   = otag_q;
  assign o_pass  = pass_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_gcm_tag_verify.sv
// Directed bench for gcm_tag_verify: identity multiply, GCM test cases 1 and 2,
// handshake holding, start/reset during MULT, and the 8-bit-per-cycle variant.
module tb_gcm_tag_verify;
  import gcm_pkg::*;

  localparam gf128_t H_ID  = 128'h80000000000000000000000000000000;
  localparam gf128_t Y_ID  = 128'h0123456789abcdef0123456789abcdef;
  localparam gf128_t H_TC  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam gf128_t EKJ0  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam gf128_t B1    = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam gf128_t B2    = 128'h00000000000000000000000000000080;
  localparam gf128_t TAG2  = 128'hab6e47d42cec13bdf53a67b21257bddf;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // shared stimulus, per-instance start/valid
  gf128_t h_in = '0, blk_data = '0, ekj0_in = '0, tag_in = '0;
  logic   blk_last = 1'b0;
  logic   start1 = 1'b0, valid1 = 1'b0, start8 = 1'b0, valid8 = 1'b0;
  logic   rdy1, busy1, done1, pass1, rdy8, busy8, done8, pass8;
  gf128_t tag1, tag8;
  logic [2:0] st1, st8;

  int nvec = 0;
  int nerr = 0;

  gcm_tag_verify #(.BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .i_reset(rst), .i_start(start1), .i_h(h_in),
    .i_blk_valid(valid1), .o_blk_ready(rdy1), .i_blk_data(blk_data),
    .i_blk_last(blk_last), .i_ekj0(ekj0_in), .i_tag(tag_in),
    .o_busy(busy1), .o_done(done1), .o_tag(tag1), .o_pass(pass1), .o_state(st1)
  );

  gcm_tag_verify #(.BITS_PER_CYCLE(8)) u_dut8 (
    .clk(clk), .i_reset(rst), .i_start(start8), .i_h(h_in),
    .i_blk_valid(valid8), .o_blk_ready(rdy8), .i_blk_data(blk_data),
    .i_blk_last(blk_last), .i_ekj0(ekj0_in), .i_tag(tag_in),
    .o_busy(busy8), .o_done(done8), .o_tag(tag8), .o_pass(pass8), .o_state(st8)
  );

  function automatic logic   g_rdy (input int s); return (s == 8) ? rdy8  : rdy1;  endfunction
  function automatic logic   g_done(input int s); return (s == 8) ? done8 : done1; endfunction
  function automatic logic   g_busy(input int s); return (s == 8) ? busy8 : busy1; endfunction
  function automatic logic   g_pass(input int s); return (s == 8) ? pass8 : pass1; endfunction
  function automatic gf128_t g_tag (input int s); return (s == 8) ? tag8  : tag1;  endfunction
  function automatic logic [2:0] g_st(input int s); return (s == 8) ? st8 : st1;   endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // driver tasks: all enter and leave at a falling edge
  task automatic set_valid(input int s, input logic v);
    if (s == 8) valid8 = v; else valid1 = v;
  endtask

  task automatic pulse_start(input int s, input gf128_t h);
    h_in = h;
    if (s == 8) start8 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic send_block(input int s, input gf128_t d, input logic l,
                            input gf128_t e, input gf128_t t, output int acc);
    acc = -1;
    blk_data = d; blk_last = l; ekj0_in = e; tag_in = t;
    set_valid(s, 1'b1);
    for (int k = 0; k < 400; k++) begin
      if (g_rdy(s)) begin
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    set_valid(s, 1'b0);
  endtask

  task automatic finish_check(input string tc, input int s, input int acc, input int lat,
                              input gf128_t exp_tag, input logic exp_pass);
    int dc;
    dc = -1;
    for (int k = 0; k < 400; k++) begin
      if (g_done(s)) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
    end
    chk({tc, "_latency"}, 128'(dc - acc), 128'(lat));
    @(negedge clk);
    chk({tc, "_tag"},   g_tag(s),          exp_tag);
    chk({tc, "_pass"},  128'(g_pass(s)),   128'(exp_pass));
    chk({tc, "_done_pulse"}, 128'(g_done(s)), 128'(0));
    chk({tc, "_state"}, 128'(g_st(s)),     128'(DONE));
  endtask

  initial begin
    int acc, acc1, acc2, rdy_again, dc, n_acc, viol, extra, ndone;
    logic will;
    gf128_t bad_tag;

    // reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_state", 128'(st1), 128'(IDLE));
    chk("rst_ready", 128'(rdy1), 128'(0));
    chk("rst_busy",  128'(busy1), 128'(0));
    chk("rst_done",  128'(done1), 128'(0));
    chk("rst_pass",  128'(pass1), 128'(0));
    chk("rst_tag",   tag1, 128'(0));

    // valid in IDLE is ignored
    valid1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_valid_state", 128'(st1), 128'(IDLE));
    chk("idle_valid_ready", 128'(rdy1), 128'(0));
    valid1 = 1'b0;

    // identity multiply: H = 1, tag = block
    pulse_start(1, H_ID);
    chk("id_ready_after_start", 128'(rdy1), 128'(1));
    send_block(1, Y_ID, 1'b1, '0, Y_ID, acc);
    finish_check("id", 1, acc, 129, Y_ID, 1'b1);
    chk("id_busy_done", 128'(busy1), 128'(0));

    // GCM TC1: single zero length block
    pulse_start(1, H_TC);
    chk("tc1_tag_cleared", tag1, 128'(0));
    chk("tc1_pass_cleared", 128'(pass1), 128'(0));
    send_block(1, '0, 1'b1, EKJ0, EKJ0, acc);
    finish_check("tc1", 1, acc, 129, EKJ0, 1'b1);

    // GCM TC2 with valid held high, and a start pulse mid-MULT
    pulse_start(1, H_TC);
    ekj0_in = EKJ0; tag_in = TAG2;
    blk_data = B1; blk_last = 1'b0; valid1 = 1'b1;
    n_acc = 0; viol = 0; acc1 = -1; acc2 = -1; rdy_again = -1; dc = -1;
    for (int k = 0; k < 600; k++) begin
      if (done1) begin
        dc = cyc;
        break;
      end
      if (st1 == MULT && rdy1) viol++;
      if (n_acc == 1 && rdy1 && rdy_again < 0) rdy_again = cyc;
      start1 = (k == 60);
      will = rdy1 && valid1;
      @(posedge clk);
      @(negedge clk);
      if (will) begin
        n_acc++;
        if (n_acc == 1) begin
          acc1 = cyc;
          blk_data = B2;
          blk_last = 1'b1;
        end else begin
          acc2 = cyc;
        end
      end
    end
    start1 = 1'b0;
    chk("tc2_ready_again", 128'(rdy_again - acc1), 128'(129));
    chk("tc2_ready_low_mult", 128'(viol), 128'(0));
    chk("tc2_done_latency", 128'(dc - acc2), 128'(129));
    @(negedge clk);
    chk("tc2_tag",  tag1, TAG2);
    chk("tc2_pass", 128'(pass1), 128'(1));
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      if (rdy1) extra++;
      @(negedge clk);
    end
    chk("tc2_no_extra_ready", 128'(extra), 128'(0));
    chk("tc2_blocks", 128'(n_acc), 128'(2));
    valid1 = 1'b0;

    // TC2 with tag bit 127 flipped
    bad_tag = TAG2;
    bad_tag[127] = ~bad_tag[127];
    pulse_start(1, H_TC);
    send_block(1, B1, 1'b0, '0, '0, acc);
    send_block(1, B2, 1'b1, EKJ0, bad_tag, acc);
    finish_check("tc2bad", 1, acc, 129, TAG2, 1'b0);

    // reset during MULT, then rerun
    pulse_start(1, H_TC);
    send_block(1, B1, 1'b0, '0, '0, acc);
    repeat (30) @(negedge clk);
    chk("mid_state_mult", 128'(st1), 128'(MULT));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_state", 128'(st1), 128'(IDLE));
    chk("mrst_ready", 128'(rdy1), 128'(0));
    chk("mrst_busy",  128'(busy1), 128'(0));
    chk("mrst_done",  128'(done1), 128'(0));
    chk("mrst_pass",  128'(pass1), 128'(0));
    chk("mrst_tag",   tag1, 128'(0));
    ndone = 0;
    for (int k = 0; k < 200; k++) begin
      if (done1) ndone++;
      @(negedge clk);
    end
    chk("mrst_no_done", 128'(ndone), 128'(0));
    pulse_start(1, H_TC);
    send_block(1, B1, 1'b0, '0, '0, acc);
    send_block(1, B2, 1'b1, EKJ0, TAG2, acc);
    finish_check("rerun", 1, acc, 129, TAG2, 1'b1);

    // TC2 on the 8-bit-per-cycle instance
    pulse_start(8, H_TC);
    send_block(8, B1, 1'b0, '0, '0, acc);
    send_block(8, B2, 1'b1, EKJ0, TAG2, acc);
    finish_check("bpc8", 8, acc, 17, TAG2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/gcm_tag_verify.md
Name: gcm_tag_verify

Overview:
Receive-side GCM authentication block: the checker that matches the tag generator.
- Accumulates GHASH over a stream of 128-bit blocks (AAD, ciphertext, length block) using an iterative GF(2^128) multiplier, so no full-width combinational product is needed.
- Masks the hash with E_K(J0) and compares the result against the received tag.
- Sits in the decrypt path after the block formatter, alongside the CTR keystream unit.

Parameters:
BITS_PER_CYCLE, 1, multiplier bits consumed per cycle; legal values 1, 2, 4, 8 (must divide 128).

Ports:
clk  in  1  system clock (clk_out domain)
i_reset  in  1  synchronous active-high reset
i_start  in  1  pulse: load hash subkey, clear accumulator (honoured only in IDLE or DONE)
i_h  in  [0:127]  hash subkey H = E_K(0^128), sampled on i_start
i_blk_valid  in  1  block offered
o_blk_ready  out  1  block can be accepted
i_blk_data  in  [0:127]  AAD/ciphertext/length block, GCM bit order
i_blk_last  in  1  marks final (length) block; sampled with the block
i_ekj0  in  [0:127]  E_K(J0) mask; sampled with the last block
i_tag  in  [0:127]  received tag; sampled with the last block
o_busy  out  1  high in WAIT_BLK, MULT, FINAL
o_done  out  1  one-cycle pulse when the result is valid
o_tag  out  [0:127]  computed tag (GHASH xor E_K(J0)); held until next i_start
o_pass  out  1  1 when o_tag == captured i_tag; held until next i_start

Behaviour:
- Reset: state IDLE; X, H, o_tag, and captured tag/mask cleared to 0; o_blk_ready=0, o_busy=0, o_done=0, o_pass=0. Reset mid-operation aborts immediately; no done pulse.
- Bit order: index 0 is the x^0 coefficient (MSB of byte 0). R = 11100001 followed by 120 zeros.
- Multiply, per NIST SP 800-38D Alg. 1:
  - Z=0, V=H.
  - For i=0..127: if Y[i] then Z^=V. Then V = V[127] ? (V>>1)^R : V>>1, where ">>" shifts toward higher index.
  - BITS_PER_CYCLE unrolled steps per clock; 128/BITS_PER_CYCLE cycles per block.
- States:
  - IDLE: o_blk_ready=0. i_start → load H, clear X → WAIT_BLK.
  - WAIT_BLK: o_blk_ready=1. On valid&&ready: Y ← X ^ i_blk_data, latch last flag; if last, also latch i_ekj0 and i_tag. Go to MULT.
  - MULT: o_blk_ready=0. Step counter runs 0 .. 128/BITS_PER_CYCLE-1. On the final step X ← Z; go to FINAL if last, else WAIT_BLK.
  - FINAL: o_tag ← X ^ ekj0; o_pass ← (X ^ ekj0) == tag; o_done=1 this cycle → DONE.
  - DONE: o_busy=0; outputs held. i_start → same as from IDLE (o_pass and o_tag cleared on start).
- Latency: block accepted at edge N; o_blk_ready high again at N+128/BITS_PER_CYCLE+1 for a non-last block. For the last block, o_done is asserted in cycle N+128/BITS_PER_CYCLE+1 (with BITS_PER_CYCLE=1, 129 cycles after acceptance).
- Back-to-back: at most one block per multiply period; valid may be held high indefinitely without loss.
- i_start while in WAIT_BLK, MULT or FINAL: ignored.
- i_blk_valid in IDLE or DONE: ignored (ready low).
- A message is at least one block (the length block always carries i_blk_last).
- Comparison: constant-time full 128-bit equality, no early exit.

Decomposition:
- gcm_pkg holds: typedef logic [0:127] gf128_t; localparam GCM_R; state enum {IDLE, WAIT_BLK, MULT, FINAL, DONE}.
- Sub-module gf128_mult_serial (parameter BITS_PER_CYCLE; start/operands in, done/product out) performs the iterative multiply.
- gcm_tag_verify holds the FSM, accumulator, capture registers and compare.

Test Plan:
- Identity multiply: H=80000000000000000000000000000000, one last block 0123456789abcdef0123456789abcdef, ekj0=0, tag=same value → o_tag=0123456789abcdef0123456789abcdef, o_pass=1, o_done exactly 129 cycles after acceptance (BITS_PER_CYCLE=1).
- GCM TC1: H=66e94bd4ef8a2c3b884cfa59ca342b2e, single length block 0, ekj0=58e2fccefa7e3061367f1d57a4e7455a, tag=58e2fccefa7e3061367f1d57a4e7455a → o_pass=1, o_tag equal to that tag.
- GCM TC2: same H and ekj0, blocks 0388dace60b6a392f328c2b971b2fe78 then 00000000000000000000000000000080 (last), tag=ab6e47d42cec13bdf53a67b21257bddf → o_tag matches, o_pass=1. Repeat with tag bit 127 flipped → same o_tag, o_pass=0.
- Handshake: hold i_blk_valid high through TC2 → exactly 2 blocks consumed; o_blk_ready low throughout MULT. i_start pulsed mid-MULT → ignored, result unchanged.
- Reset mid-MULT during TC2 → next cycle state IDLE, all outputs 0, no o_done. Rerun TC2 → o_pass=1.
- Repeat TC2 with BITS_PER_CYCLE=8 → identical o_tag, o_done 17 cycles after last-block acceptance.
